// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding,
// the default operand width and the bit-counter width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Bit counter width: enough to count 0..WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Team 1-bit full-adder cell. Purely combinational; the serial controller
// time-multiplexes a single instance over every operand bit.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller. One full-adder cell adds WIDTH-bit operands
// LSB first, one bit per clock, with the carry held in a flop between bits.
// Operands are taken over a valid/ready handshake; sum and carry-out are
// registered and held until the consumer accepts them.
// Optional feature: define SERIAL_SUB_EN to add the op_sub input, which turns
// the operation into op_a - op_b (res_cout=1 means no borrow).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             op_sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH:0]   sum_cat;
    logic [WIDTH-1:0] sum_shifted;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder u_cell (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_sum),
        .co_o (fa_cout)
    );

    // New sum bit enters at the MSB while the partial sum moves one place right;
    // the WIDTH+1 concatenation keeps this valid for WIDTH=1 as well.
    assign sum_cat     = {fa_sum, sum_sh_q};
    assign sum_shifted = sum_cat[WIDTH:1];

    // Operand adjustment on accept: subtraction is a + ~b + 1.
`ifdef SERIAL_SUB_EN
    assign b_load     = op_sub ? ~op_b : op_b;
    assign carry_load = op_sub ? 1'b1  : cin;
`else
    assign b_load     = op_b;
    assign carry_load = cin;
`endif

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    state_d = S_SHIFT;
                    a_sh_d  = op_a;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_shifted;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    sum_d   = sum_shifted;
                    cout_d  = fa_cout;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, shift registers, carry flop, counter and result registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the data registers are reset too, so outputs read 0 immediately after reset or an abort.
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q == S_SHIFT);
    assign res_valid   = (state_q == S_DONE);
    assign res_sum     = sum_q;
    assign res_cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). A cycle-level
// behavioural model (arithmetic result plus busy/valid timing) is compared
// against the DUT on every falling edge; directed cases also check literal
// results. Define SERIAL_SUB_EN to exercise the subtract option.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             op_sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             busy;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
`ifdef SERIAL_SUB_EN
        .op_sub      (op_sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result the specification demands: plain (WIDTH+1)-bit arithmetic.
    function automatic logic [WIDTH:0] model_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                    input logic c, input logic s);
        logic [WIDTH:0] r;
        logic           sub_on;
`ifdef SERIAL_SUB_EN
        sub_on = s;
`else
        sub_on = 1'b0;
`endif
        if (sub_on)
            r = {1'b0, a} + (WIDTH + 1)'(1 << WIDTH) - {1'b0, b};
        else
            r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        return r;
    endfunction

    // Behavioural model: an accepted operation keeps the block busy for WIDTH
    // cycles, then the result is offered until consumed.
    int             m_left  = 0;
    bit             m_valid = 1'b0;
    logic [WIDTH:0] m_res   = '0;
    logic [WIDTH:0] m_pend  = '0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_left  = 0;
            m_valid = 1'b0;
            m_res   = '0;
            m_pend  = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_res   = m_pend;
            end
        end else if (m_valid) begin
            if (res_ready) m_valid = 1'b0;
        end else if (start_valid) begin
            m_left = WIDTH;
            m_pend = model_result(op_a, op_b, cin, op_sub);
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge sys_clk) begin
        check("cycle_outputs",
              {60'd0, start_ready, busy, res_valid, 1'b0} << WIDTH | {res_cout, res_sum},
              {60'd0, (m_left == 0 && !m_valid), (m_left > 0), m_valid, 1'b0} << WIDTH | m_res);
    end

    // One complete transaction driven through the handshakes.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input logic s, input int hold, input bit pulse,
                          input bit pin, input logic [WIDTH:0] pin_val, input string tag);
        logic [WIDTH:0] exp;
        int             guard;
        int             n;
        exp = pin ? pin_val : model_result(a, b, c, s);

        guard = 0;
        while (!start_ready && guard < 100) begin
            @(posedge sys_clk); #1;
            guard++;
        end
        if (guard >= 100) check({tag, "_idle_timeout"}, 64'd0, 64'd1);

        start_valid = 1'b1;
        op_a = a; op_b = b; cin = c; op_sub = s;
        @(posedge sys_clk); #1;
        start_valid = 1'b0;
        op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);

        n = 0;
        while (n < 50) begin
            if (pulse && n == 3) start_valid = 1'b1;
            else start_valid = 1'b0;
            res_ready = 1'($urandom);
            @(posedge sys_clk); #1;
            n++;
            if (res_valid) break;
        end
        start_valid = 1'b0;
        res_ready   = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(WIDTH));
        check({tag, "_result"}, {res_cout, res_sum}, exp);

        for (int i = 0; i < hold; i++) begin
            @(posedge sys_clk); #1;
            check({tag, "_hold_valid"}, res_valid, 1'b1);
            check({tag, "_hold_result"}, {res_cout, res_sum}, exp);
            check({tag, "_hold_ready"}, start_ready, 1'b0);
        end

        res_ready = 1'b1;
        @(posedge sys_clk); #1;
        res_ready = 1'b0;
        check({tag, "_consume_ready"}, start_ready, 1'b1);
        check({tag, "_consume_valid"}, res_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n   = 1'b0;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        cin         = 1'b0;
        op_sub      = 1'b0;
        res_ready   = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_outputs", {start_ready, busy, res_valid, res_cout, res_sum}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        run_op(8'h35, 8'h4A, 1'b0, 1'b0, 5, 1'b0, 1'b1, 9'h07F, "add_35_4a");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1, 9'h100, "add_wrap");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1, 1'b1, 1'b1, 9'h1FF, "add_ff_ff_pulse");

        // Abort mid-operation with an asynchronous reset at bit 3.
        start_valid = 1'b1;
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0; op_sub = 1'b0;
        @(posedge sys_clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("abort_busy_before", busy, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check("abort_outputs", {start_ready, busy, res_valid, res_cout, res_sum}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        #1;
        sys_rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1, 9'h002, "after_reset");

`ifdef SERIAL_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0, 1'b1, 9'h10F, "sub_10_01");
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, 1'b0, 1'b1, 9'h0FF, "sub_01_02");
`endif

        for (int k = 0; k < 40; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b0, '0, "random");
        end

        repeat (2) @(posedge sys_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
